// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic valid/ready pipeline register with one main entry and
// one skid entry. It sustains one transfer per cycle, and in_ready comes
// straight from a flop, so there is no combinational path from out_ready.
// A synchronous flush squashes held entries on a redirect.
//
// Optional build macro PIPE_STALL_CNT_EN adds a saturating stall_cnt output.
// It counts cycles with out_valid = 1 and out_ready = 0.
//
// State encoding is the {main_v, skid_v} pair:
//   state | meaning
//   EMPTY | 00, nothing held
//   ONE   | 10, main entry valid, skid empty
//   FULL  | 11, main and skid valid, in_ready low
// The pattern 01 is never produced.
module pipe_skid_reg #(
    parameter int WIDTH      = 32,
    parameter bit CLEAR_DATA = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             in_fire;
    logic             out_fire;

    if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
        $error("pipe_skid_reg: WIDTH and CNT_W must be at least 1");
    end

    // Bit 1 of the state is main_v and bit 0 is skid_v, so both outputs are flop outputs.
    assign out_valid = state[1];
    assign in_ready  = ~state[0];
    assign out_data  = main_data;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Occupancy FSM and data registers; flush wins over any handshake in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            main_data <= '0;
            skid_data <= '0;
        end else if (flush) begin
            state <= EMPTY;
            if (CLEAR_DATA) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_data <= in_data;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    case ({out_fire, in_fire})
                        2'b11: main_data <= in_data;
                        2'b10: state     <= EMPTY;
                        2'b01: begin
                            skid_data <= in_data;
                            state     <= FULL;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    // in_ready is low here, so only the drain case can occur.
                    if (out_fire) begin
                        main_data <= skid_data;
                        state     <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    // Saturating backpressure counter; only reset clears it, so flush leaves history intact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule
